// File: rtl/rr_grant_scheduler_pkg.sv
// Shared types and constants for the round-robin grant scheduler.
package rr_grant_scheduler_pkg;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  // 2'b11 is unused; the FSM recovers from it to IDLE
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    OWN     = 2'b01,
    RELEASE = 2'b10
  } state_t;

  function automatic logic [NREQ-1:0] id2onehot(input logic [ID_W-1:0] id);
    id2onehot     = '0;
    id2onehot[id] = 1'b1;
  endfunction
endpackage

// File: rtl/rr_grant_scheduler_if.sv
// Requester-side handshake bundle: req/done in, grant status out.
interface rr_grant_scheduler_if;
  import rr_grant_scheduler_pkg::*;

  logic [NREQ-1:0] req;
  logic            done;
  logic [NREQ-1:0] grant;
  logic [ID_W-1:0] grant_id;
  logic            busy;
  logic            timeout;

  modport master (output req, done, input grant, grant_id, busy, timeout);
  modport slave  (input req, done, output grant, grant_id, busy, timeout);
endinterface

// File: rtl/rr_grant_scheduler_pick.sv
// Rotating-priority picker: first set request after i_ptr, wrapping to i_ptr last.
module rr_pick
  import rr_grant_scheduler_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic            o_found,
  output logic [ID_W-1:0] o_pick_id
);

  logic [ID_W-1:0] w_idx;

  // Scan farthest-to-nearest so the nearest set bit after i_ptr wins
  always_comb begin
    o_found   = 1'b0;
    o_pick_id = '0;
    w_idx     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = i_ptr + ID_W'(k);
      if (i_req[w_idx]) begin
        o_found   = 1'b1;
        o_pick_id = w_idx;
      end
    end
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin owner scheduler for a shared datapath: IDLE -> OWN -> RELEASE,
// with ownership bounded to MAX_HOLD cycles.
module rr_grant_scheduler
  import rr_grant_scheduler_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_grant_scheduler_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_HOLD) + 1;

  state_t          r_state,    w_state_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_nxt;
  logic [ID_W-1:0] r_ptr,      w_ptr_nxt;
  logic [NREQ-1:0] r_grant,    w_grant_nxt;
  logic [ID_W-1:0] r_gid,      w_gid_nxt;
  logic            r_busy,     w_busy_nxt;
  logic            r_timeout,  w_timeout_nxt;

  logic            w_found;
  logic [ID_W-1:0] w_pick_id;
  logic            w_owner_req;
  logic            w_limit;

  rr_pick u_pick (
    .i_req     (bus.req),
    .i_ptr     (r_ptr),
    .o_found   (w_found),
    .o_pick_id (w_pick_id)
  );

  assign w_owner_req = bus.req[r_gid];
  assign w_limit     = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));

  // Next-state and next-output decode; outputs are registered below
  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold_cnt;
    w_ptr_nxt     = r_ptr;
    w_grant_nxt   = r_grant;
    w_gid_nxt     = r_gid;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        if (w_found) begin
          w_state_nxt = OWN;
          w_grant_nxt = id2onehot(w_pick_id);
          w_gid_nxt   = w_pick_id;
          w_hold_nxt  = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      OWN: begin
        w_hold_nxt = r_hold_cnt + 1'b1;
        if (bus.done || !w_owner_req || w_limit) begin
          w_state_nxt   = RELEASE;
          w_grant_nxt   = '0;
          w_busy_nxt    = 1'b0;
          w_ptr_nxt     = r_gid;
          // Only a pure hold-limit expiry counts as a timeout
          w_timeout_nxt = w_limit && !bus.done && w_owner_req;
        end
      end
      RELEASE: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  // State, counter, pointer and output registers; reset parks ptr at 3
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_ptr      <= ID_W'(NREQ - 1);
      r_grant    <= '0;
      r_gid      <= '0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant    <= w_grant_nxt;
      r_gid      <= w_gid_nxt;
      r_busy     <= w_busy_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign bus.grant    = r_grant;
  assign bus.grant_id = r_gid;
  assign bus.busy     = r_busy;
  assign bus.timeout  = r_timeout;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Bench for rr_grant_scheduler: directed vectors with literal expectations,
// plus an owner/phase model compared against the DUT on every falling edge.
module tb_rr_grant_scheduler;
  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_grant_scheduler_if bus();
  rr_grant_scheduler #(.MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: who owns, how many cycles owned, who owned last, phase
  // (0 = nobody, 1 = owning, 2 = release gap), and whether it timed out
  int m_phase = 0;
  int m_owner = 0;
  int m_owned = 0;
  int m_last  = 3;
  bit m_to    = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0; m_owner = 0; m_owned = 0; m_last = 3; m_to = 0;
    end else begin
      case (m_phase)
        0: begin
          m_to = 0;
          if (bus.req != 4'b0000) begin
            bit got;
            got = 0;
            for (int k = 1; k <= 4; k++)
              if (!got && bus.req[(m_last + k) % 4]) begin
                got = 1;
                m_owner = (m_last + k) % 4;
              end
            m_phase = 1;
            m_owned = 1;
          end
        end
        1: begin
          if (bus.done || !bus.req[m_owner] || m_owned == MAX_HOLD) begin
            m_to    = (m_owned == MAX_HOLD) && !bus.done && bus.req[m_owner];
            m_last  = m_owner;
            m_phase = 2;
          end else begin
            m_owned++;
          end
        end
        default: begin
          m_phase = 0;
          m_to    = 0;
        end
      endcase
    end
  end

  // Cycle-by-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      logic [3:0] eg;
      eg = (m_phase == 1) ? 4'(1 << m_owner) : 4'b0000;
      chk("model_grant", 32'(bus.grant), 32'(eg));
      chk("model_busy", 32'(bus.busy), 32'(m_phase == 1));
      chk("model_timeout", 32'(bus.timeout), 32'(m_phase == 2 && m_to));
      if (m_phase == 1) chk("model_grant_id", 32'(bus.grant_id), 32'(m_owner));
      chk("model_onehot", 32'($countones(bus.grant) <= 1), 32'd1);
    end
  end

  initial begin
    rst = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // 1: asynchronous reset mid-cycle while a grant is live
    bus.req = 4'b1111;
    tick();
    chk("t1_pre_grant", 32'(bus.grant), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("t1_rst_grant", 32'(bus.grant), 32'h0);
    chk("t1_rst_gid", 32'(bus.grant_id), 32'h0);
    chk("t1_rst_busy", 32'(bus.busy), 32'h0);
    chk("t1_rst_timeout", 32'(bus.timeout), 32'h0);
    bus.req = 4'b0000;
    tick();
    rst = 1'b1;

    // 2: single requester, done on third owned cycle
    bus.req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_grant", 32'(bus.grant), 32'h4);
      chk("t2_gid", 32'(bus.grant_id), 32'd2);
      chk("t2_busy", 32'(bus.busy), 32'd1);
      if (i == 2) bus.done = 1'b1;
    end
    tick();
    chk("t2_rel_grant", 32'(bus.grant), 32'h0);
    chk("t2_rel_busy", 32'(bus.busy), 32'h0);
    chk("t2_rel_timeout", 32'(bus.timeout), 32'h0);
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    tick();
    chk("t2_idle_grant", 32'(bus.grant), 32'h0);

    // 3: fairness with everyone requesting and done every owned cycle
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.req  = 4'b1111;
    bus.done = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      chk("t3_fair", 32'(bus.grant), (k % 3 == 0) ? 32'(1 << ((k / 3) % 4)) : 32'h0);
    end

    // 4: hold limit with two persistent requesters (last owner was 0)
    bus.req  = 4'b0011;
    bus.done = 1'b0;
    tick();
    for (int r = 0; r < 3; r++) begin
      logic [3:0] exp_g;
      exp_g = (r == 1) ? 4'b0001 : 4'b0010;
      for (int i = 0; i < MAX_HOLD; i++) begin
        tick();
        chk("t4_hold_grant", 32'(bus.grant), 32'(exp_g));
        chk("t4_hold_timeout", 32'(bus.timeout), 32'h0);
      end
      if (r == 2) break;
      tick();
      chk("t4_to_grant", 32'(bus.grant), 32'h0);
      chk("t4_to_pulse", 32'(bus.timeout), 32'h1);
      tick();
      chk("t4_idle_timeout", 32'(bus.timeout), 32'h0);
    end

    // 5a: requester 3 withdraws on its second owned cycle
    rst = 1'b0;
    bus.req = 4'b0000;
    tick();
    rst = 1'b1;
    bus.req = 4'b1000;
    tick();
    chk("t5_grant", 32'(bus.grant), 32'h8);
    tick();
    chk("t5_grant2", 32'(bus.grant), 32'h8);
    bus.req = 4'b0000;
    tick();
    chk("t5_wd_grant", 32'(bus.grant), 32'h0);
    chk("t5_wd_timeout", 32'(bus.timeout), 32'h0);
    tick();

    // 5b: done coincides with the hold limit
    bus.req = 4'b1000;
    for (int i = 1; i <= MAX_HOLD; i++) begin
      tick();
      chk("t5b_grant", 32'(bus.grant), 32'h8);
      if (i == MAX_HOLD) bus.done = 1'b1;
    end
    tick();
    chk("t5b_rel_grant", 32'(bus.grant), 32'h0);
    chk("t5b_rel_timeout", 32'(bus.timeout), 32'h0);
    bus.done = 1'b0;

    // 6: reset while requester 3 owns, then pointer restarts at 0
    tick();
    chk("t6_idle", 32'(bus.grant), 32'h0);
    tick();
    chk("t6_own", 32'(bus.grant), 32'h8);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(bus.grant), 32'h0);
    chk("t6_rst_busy", 32'(bus.busy), 32'h0);
    chk("t6_rst_timeout", 32'(bus.timeout), 32'h0);
    bus.req = 4'b1001;
    tick();
    rst = 1'b1;
    tick();
    chk("t6_first_grant", 32'(bus.grant), 32'h1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
